// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter between the in-order WB stage and the mul/div unit.
// The winning write is registered, and exit is held back until md results drain.
module wb_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_wen_i,
  input  logic [4:0]  pipe_rd_i,
  input  logic [63:0] pipe_wdata_i,
  input  logic        pipe_exit_i,
  input  logic [63:0] pipe_pc_i,
  output logic        pipe_stall_o,
  input  logic        md_valid_i,
  input  logic [4:0]  md_rd_i,
  input  logic [63:0] md_wdata_i,
  input  logic        md_busy_i,
  output logic        md_ready_o,
  output logic        wen_o,
  output logic [4:0]  rd_o,
  output logic [63:0] wdata_o,
  output logic        exit_o,
  output logic [63:0] exit_pc_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;

  logic pipe_req;
  logic md_req;
  logic starve_hit;
  logic md_win;
  logic pipe_win;
  logic exit_take;

  // Arbitration decode; the handshake outputs depend only on state, counter and requests.
  always_comb begin
    pipe_req     = pipe_wen_i & (pipe_rd_i != 5'd0);
    md_req       = md_valid_i;
    starve_hit   = pipe_req & md_req & (starve_cnt >= STARVE_LIM);
    md_win       = 1'b0;
    pipe_win     = 1'b0;
    exit_take    = 1'b0;
    pipe_stall_o = 1'b1;
    md_ready_o   = 1'b0;
    case (state)
      RUN: begin
        md_win       = md_req & (~pipe_req | starve_hit);
        pipe_win     = pipe_req & ~md_win;
        pipe_stall_o = starve_hit;
        md_ready_o   = md_win;
        exit_take    = pipe_exit_i & ~starve_hit;
      end
      DRAIN: begin
        md_win     = md_valid_i;
        md_ready_o = md_valid_i;
      end
      default: ;
    endcase
  end

  // State, starvation counter and the registered write/exit outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      starve_cnt <= '0;
      wen_o      <= 1'b0;
      rd_o       <= 5'd0;
      wdata_o    <= 64'd0;
      exit_o     <= 1'b0;
      exit_pc_o  <= 64'd0;
    end else begin
      wen_o      <= 1'b0;
      exit_o     <= 1'b0;
      starve_cnt <= '0;

      // An md result with rd=0 completes its handshake but never writes.
      if (md_win && (md_rd_i != 5'd0)) begin
        wen_o   <= 1'b1;
        rd_o    <= md_rd_i;
        wdata_o <= md_wdata_i;
      end else if (pipe_win) begin
        wen_o   <= 1'b1;
        rd_o    <= pipe_rd_i;
        wdata_o <= pipe_wdata_i;
      end

      case (state)
        RUN: begin
          if (pipe_req && md_req && !starve_hit) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
          if (exit_take) begin
            exit_pc_o <= pipe_pc_i;
            if (md_busy_i || md_valid_i) begin
              state <= DRAIN;
            end else begin
              state  <= DONE;
              exit_o <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!md_busy_i && !md_valid_i) begin
            state  <= DONE;
            exit_o <= 1'b1;
          end
        end
        DONE:    ;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: inputs change on the falling edge,
// combinational outputs are checked before the rising edge, registered ones 1ns after.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        pipe_wen;
  logic [4:0]  pipe_rd;
  logic [63:0] pipe_wdata;
  logic        pipe_exit;
  logic [63:0] pipe_pc;
  logic        pipe_stall;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [63:0] md_wdata;
  logic        md_busy;
  logic        md_ready;
  logic        wen;
  logic [4:0]  rd;
  logic [63:0] wdata;
  logic        exit_p;
  logic [63:0] exit_pc;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] EXIT_PC = 64'h0000_0000_8000_0010;

  wb_port_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_wen_i   (pipe_wen),
    .pipe_rd_i    (pipe_rd),
    .pipe_wdata_i (pipe_wdata),
    .pipe_exit_i  (pipe_exit),
    .pipe_pc_i    (pipe_pc),
    .pipe_stall_o (pipe_stall),
    .md_valid_i   (md_valid),
    .md_rd_i      (md_rd),
    .md_wdata_i   (md_wdata),
    .md_busy_i    (md_busy),
    .md_ready_o   (md_ready),
    .wen_o        (wen),
    .rd_o         (rd),
    .wdata_o      (wdata),
    .exit_o       (exit_p),
    .exit_pc_o    (exit_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    pipe_wen   = 1'b0;
    pipe_rd    = 5'd0;
    pipe_wdata = 64'd0;
    pipe_exit  = 1'b0;
    pipe_pc    = 64'd0;
    md_valid   = 1'b0;
    md_rd      = 5'd0;
    md_wdata   = 64'd0;
    md_busy    = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (wen !== 1'b0 || rd !== 5'd0 || wdata !== 64'd0) begin
      errors++; $display("FAIL reset_write wen=%b rd=%0d wdata=%h required 0 0 0", wen, rd, wdata);
    end
    checks++;
    if (exit_p !== 1'b0 || exit_pc !== 64'd0) begin
      errors++; $display("FAIL reset_exit exit=%b pc=%h required 0 0", exit_p, exit_pc);
    end
    checks++;
    if (pipe_stall !== 1'b0 || md_ready !== 1'b0) begin
      errors++; $display("FAIL reset_comb stall=%b ready=%b required 0 0", pipe_stall, md_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pipe_only();
    @(negedge clk);
    idle_inputs();
    pipe_wen = 1'b1; pipe_rd = 5'd5; pipe_wdata = 64'h1234;
    #1;
    checks++;
    if (pipe_stall !== 1'b0 || md_ready !== 1'b0) begin
      errors++; $display("FAIL pipe_only_comb stall=%b ready=%b required 0 0", pipe_stall, md_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (wen !== 1'b1 || rd !== 5'd5 || wdata !== 64'h1234) begin
      errors++; $display("FAIL pipe_only_write wen=%b rd=%0d wdata=%h required 1 5 1234", wen, rd, wdata);
    end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    checks++;
    if (wen !== 1'b0 || rd !== 5'd5 || wdata !== 64'h1234) begin
      errors++; $display("FAIL pipe_only_hold wen=%b rd=%0d wdata=%h required 0 5 1234", wen, rd, wdata);
    end
  endtask

  task automatic test_md_only();
    @(negedge clk);
    idle_inputs();
    md_valid = 1'b1; md_rd = 5'd7; md_wdata = 64'hdead;
    #1;
    checks++;
    if (md_ready !== 1'b1 || pipe_stall !== 1'b0) begin
      errors++; $display("FAIL md_only_comb ready=%b stall=%b required 1 0", md_ready, pipe_stall);
    end
    @(posedge clk); #1;
    checks++;
    if (wen !== 1'b1 || rd !== 5'd7 || wdata !== 64'hdead) begin
      errors++; $display("FAIL md_only_write wen=%b rd=%0d wdata=%h required 1 7 dead", wen, rd, wdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_contention();
    int p;
    logic exp_md;
    logic [4:0] exp_rd;
    p = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pipe_wen = 1'b1; pipe_rd = 5'(10 + p); pipe_wdata = 64'(p);
      md_valid = 1'b1; md_rd = 5'd20; md_wdata = 64'hbeef;
      exp_md = ((i % 5) == 4);
      #1;
      checks++;
      if (pipe_stall !== exp_md || md_ready !== exp_md) begin
        errors++; $display("FAIL contention_comb[%0d] stall=%b ready=%b required %b %b", i, pipe_stall, md_ready, exp_md, exp_md);
      end
      exp_rd = exp_md ? 5'd20 : 5'(10 + p);
      @(posedge clk); #1;
      checks++;
      if (wen !== 1'b1 || rd !== exp_rd) begin
        errors++; $display("FAIL contention_write[%0d] wen=%b rd=%0d required 1 %0d", i, wen, rd, exp_rd);
      end
      if (!exp_md) p++;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    @(negedge clk);
    idle_inputs();
    pipe_wen = 1'b1; pipe_rd = 5'd0; pipe_wdata = 64'h55;
    md_valid = 1'b1; md_rd = 5'd3; md_wdata = 64'h33;
    #1;
    checks++;
    if (pipe_stall !== 1'b0 || md_ready !== 1'b1) begin
      errors++; $display("FAIL rd0_pipe_comb stall=%b ready=%b required 0 1", pipe_stall, md_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (wen !== 1'b1 || rd !== 5'd3 || wdata !== 64'h33) begin
      errors++; $display("FAIL rd0_pipe_write wen=%b rd=%0d wdata=%h required 1 3 33", wen, rd, wdata);
    end
    @(negedge clk);
    idle_inputs();
    md_valid = 1'b1; md_rd = 5'd0; md_wdata = 64'h77;
    #1;
    checks++;
    if (md_ready !== 1'b1) begin
      errors++; $display("FAIL rd0_md_ready ready=%b required 1", md_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (wen !== 1'b0 || rd !== 5'd3 || wdata !== 64'h33) begin
      errors++; $display("FAIL rd0_md_nowrite wen=%b rd=%0d wdata=%h required 0 3 33", wen, rd, wdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_exit_drain();
    @(negedge clk);
    idle_inputs();
    md_busy = 1'b1;
    pipe_wen = 1'b1; pipe_rd = 5'd9; pipe_wdata = 64'h99;
    pipe_exit = 1'b1; pipe_pc = EXIT_PC;
    #1;
    checks++;
    if (pipe_stall !== 1'b0) begin
      errors++; $display("FAIL exit_take_stall stall=%b required 0", pipe_stall);
    end
    @(posedge clk); #1;
    checks++;
    if (wen !== 1'b1 || rd !== 5'd9 || exit_p !== 1'b0) begin
      errors++; $display("FAIL exit_own_write wen=%b rd=%0d exit=%b required 1 9 0", wen, rd, exit_p);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      pipe_wen = 1'b1; pipe_rd = 5'd12; pipe_wdata = 64'hcc;
      md_busy = (i < 2);
      md_valid = (i == 2); md_rd = 5'd4; md_wdata = 64'h44;
      #1;
      checks++;
      if (pipe_stall !== 1'b1 || md_ready !== (i == 2)) begin
        errors++; $display("FAIL drain_comb[%0d] stall=%b ready=%b required 1 %b", i, pipe_stall, md_ready, (i == 2));
      end
      @(posedge clk); #1;
      checks++;
      if (wen !== (i == 2) || exit_p !== 1'b0 || (i == 2 && rd !== 5'd4)) begin
        errors++; $display("FAIL drain_write[%0d] wen=%b rd=%0d exit=%b required %b 4 0", i, wen, rd, exit_p, (i == 2));
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (pipe_stall !== 1'b1) begin
      errors++; $display("FAIL drain_last_stall stall=%b required 1", pipe_stall);
    end
    @(posedge clk); #1;
    checks++;
    if (exit_p !== 1'b1 || exit_pc !== EXIT_PC || wen !== 1'b0) begin
      errors++; $display("FAIL exit_pulse exit=%b pc=%h wen=%b required 1 %h 0", exit_p, exit_pc, wen, EXIT_PC);
    end
    @(negedge clk);
    pipe_wen = 1'b1; pipe_rd = 5'd8;
    md_valid = 1'b1; md_rd = 5'd6;
    #1;
    checks++;
    if (pipe_stall !== 1'b1 || md_ready !== 1'b0) begin
      errors++; $display("FAIL done_comb stall=%b ready=%b required 1 0", pipe_stall, md_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (exit_p !== 1'b0 || exit_pc !== EXIT_PC || wen !== 1'b0) begin
      errors++; $display("FAIL done_hold exit=%b pc=%h wen=%b required 0 %h 0", exit_p, exit_pc, wen, EXIT_PC);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_drain();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    md_busy = 1'b1;
    pipe_exit = 1'b1; pipe_pc = 64'h40;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    md_busy = 1'b1;
    #1;
    checks++;
    if (pipe_stall !== 1'b1) begin
      errors++; $display("FAIL in_drain_stall stall=%b required 1", pipe_stall);
    end
    rst_n = 1'b0;
    md_valid = 1'b1; md_rd = 5'd6; md_wdata = 64'h66;
    @(posedge clk); #1;
    checks++;
    if (wen !== 1'b0 || exit_p !== 1'b0) begin
      errors++; $display("FAIL drain_reset_out wen=%b exit=%b required 0 0", wen, exit_p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if (pipe_stall !== 1'b0 || md_ready !== 1'b0) begin
      errors++; $display("FAIL drain_reset_comb stall=%b ready=%b required 0 0", pipe_stall, md_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (wen !== 1'b0 || exit_p !== 1'b0) begin
      errors++; $display("FAIL drain_reset_after wen=%b exit=%b required 0 0", wen, exit_p);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_pipe_only();
    test_md_only();
    test_contention();
    test_rd_zero();
    test_exit_drain();
    test_reset_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
